// File: rtl/seq_alu_pkg.sv
// Shared opcode/state encodings for the sequential ALU (package alu_pkg).
// SEQ_ALU_MUL_EN selects whether MUL is a legal opcode.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SLTU = 3'b011,
    OP_MUL  = 3'b100,
    OP_RSVD = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu; master drives requests and out_ready.
// Valid/ready on both sides; the slave holds the response until out_ready.
interface seq_alu_if #(parameter int WIDTH = 32);

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          operand1;
  logic [WIDTH-1:0]          operand2;
  logic [alu_pkg::OP_W-1:0]  alu_control;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          result;
  logic                      is_zero;
  logic                      illegal_op;

  modport master (
    output in_valid, operand1, operand2, alu_control, out_ready,
    input  in_ready, out_valid, result, is_zero, illegal_op
  );

  modport slave (
    input  in_valid, operand1, operand2, alu_control, out_ready,
    output in_ready, out_valid, result, is_zero, illegal_op
  );

endinterface

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier, one multiplier bit per cycle (built only with SEQ_ALU_MUL_EN).
// Latency: done rises WIDTH cycles after start; no backpressure, done holds until next start.
`ifdef SEQ_ALU_MUL_EN
module seq_alu_mul #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= multiplicand;
      mplier <= multiplier;
      cnt    <= CNT_W'(WIDTH);
      busy   <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

  // Product bits above WIDTH are never formed, so the result wraps naturally.
  assign done    = busy && (cnt == '0);
  assign product = acc;

endmodule
`endif

// File: rtl/seq_alu.sv
// Sequential ALU: 1-cycle logic/arith ops, WIDTH+1-cycle MUL when SEQ_ALU_MUL_EN is defined.
// Result is held in DONE until out_ready; in_ready only in IDLE (one op per 2 cycles max).
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  state_e           state, state_next;
  alu_op_e          op;
  logic             accept;
  logic             is_mul;
  logic             illegal;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;

  assign op     = alu_op_e'(bus.alu_control);
  assign accept = bus.in_valid && (state == ST_IDLE);

`ifdef SEQ_ALU_MUL_EN
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign is_mul = (op == OP_MUL);

  seq_alu_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (accept && is_mul),
    .multiplicand (bus.operand1),
    .multiplier   (bus.operand2),
    .done         (mul_done),
    .product      (mul_product)
  );
`else
  assign is_mul = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:  alu_res = bus.operand1 & bus.operand2;
      OP_OR:   alu_res = bus.operand1 | bus.operand2;
      OP_ADD:  alu_res = bus.operand1 + bus.operand2;
      OP_SUB:  alu_res = bus.operand1 - bus.operand2;
      OP_SLT:  alu_res = WIDTH'($signed(bus.operand1) < $signed(bus.operand2));
      OP_SLTU: alu_res = WIDTH'(bus.operand1 < bus.operand2);
`ifdef SEQ_ALU_MUL_EN
      OP_MUL:  alu_res = '0;
`endif
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = is_mul ? ST_BUSY : ST_DONE;
`ifdef SEQ_ALU_MUL_EN
      ST_BUSY: if (mul_done) state_next = ST_DONE;
`else
      ST_BUSY: state_next = ST_IDLE;
`endif
      ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && !is_mul) begin
        result_q  <= alu_res;
        zero_q    <= (alu_res == '0);
        illegal_q <= illegal;
      end
`ifdef SEQ_ALU_MUL_EN
      if (state == ST_BUSY && mul_done) begin
        result_q  <= mul_product;
        zero_q    <= (mul_product == '0);
        illegal_q <= 1'b0;
      end
`endif
    end
  end

  assign bus.in_ready   = (state == ST_IDLE);
  assign bus.out_valid  = (state == ST_DONE);
  assign bus.result     = result_q;
  assign bus.is_zero    = zero_q;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu with an expectation queue; checks latency, hold, reset abort.
// MUL expectations follow SEQ_ALU_MUL_EN (reserved-opcode behaviour when undefined).
module tb_seq_alu;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    int               latency;
  } exp_t;

  logic clk;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t sb[$];

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t e;
    logic [2*WIDTH-1:0] full;
    e.result = '0; e.illegal = 1'b0; e.latency = 1;
    case (op)
      3'b000: e.result = a & b;
      3'b001: e.result = a | b;
      3'b010: e.result = a + b;
      3'b110: e.result = a - b;
      3'b111: e.result = (a[WIDTH-1] != b[WIDTH-1]) ? WIDTH'(a[WIDTH-1]) : WIDTH'(a < b);
      3'b011: e.result = WIDTH'(a < b);
      3'b100: begin
`ifdef SEQ_ALU_MUL_EN
        full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        e.result  = full[WIDTH-1:0];
        e.latency = WIDTH + 1;
`else
        full = '0;
        e.illegal = 1'b1;
`endif
      end
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  // Present a request, wait (bounded) for acceptance, then scramble the inputs.
  task automatic send(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b);
    bit ok = 1'b0;
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.operand1    = a;
    bus.operand2    = b;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_accept"}, 64'(ok), 64'd1);
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.operand1    = $urandom;
    bus.operand2    = $urandom;
    bus.alu_control = 3'($urandom_range(0, 7));
  endtask

  // Wait for the response, check latency/value, optionally stall, then drain.
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int   k = 0;
    bit   ready_seen = 1'b0;
    e = sb.pop_front();
    while (k < 200) begin
      @(posedge clk); #1;
      k++;
      if (bus.out_valid === 1'b1) break;
      if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
    end
    chk({tag, "_latency"}, 64'(k), 64'(e.latency));
    chk({tag, "_ready_low_while_busy"}, 64'(ready_seen), 64'd0);
    chk({tag, "_result"}, 64'(bus.result), 64'(e.result));
    chk({tag, "_is_zero"}, 64'(bus.is_zero), 64'(e.zero));
    chk({tag, "_illegal"}, 64'(bus.illegal_op), 64'(e.illegal));
    if (hold > 0) begin
      bit held_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
            bus.result !== e.result || bus.is_zero !== e.zero ||
            bus.illegal_op !== e.illegal)
          held_ok = 1'b0;
      end
      chk({tag, "_hold_stable"}, 64'(held_ok), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_drain_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_drain_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    exp_t discard;
    bit   stale;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.operand1    = '0;
    bus.operand2    = '0;
    bus.alu_control = '0;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_is_zero", 64'(bus.is_zero), 64'd0);
    chk("rst_illegal", 64'(bus.illegal_op), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    send("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
    collect("add_wrap", 0);
    send("slt", 3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
    collect("slt", 0);
    send("sltu", 3'b011, 32'hFFFF_FFFF, 32'h0000_0001);
    collect("sltu", 0);
    send("and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    collect("and", 0);
    send("or", 3'b001, 32'h8000_0000, 32'h0000_0001);
    collect("or", 0);
    send("sub_wrap", 3'b110, 32'h0000_0005, 32'h0000_0007);
    collect("sub_wrap", 5);
    send("mul", 3'b100, 32'h0001_0001, 32'h0001_0001);
    collect("mul", 0);
    send("rsvd", 3'b101, 32'h1234_5678, 32'h9ABC_DEF0);
    collect("rsvd", 0);

    // Reset in the middle of a MUL must abort it with no stale response.
    send("mul_abort", 3'b100, 32'h0000_0003, 32'h0000_0007);
    discard = sb.pop_front();
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("abort_out_valid_in_reset", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) stale = 1'b1;
    end
    chk("abort_no_stale_valid", 64'(stale), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    send("add_after_abort", 3'b010, 32'd2, 32'd3);
    collect("add_after_abort", 0);

    for (int i = 0; i < 8; i++) begin
      send("rand", 3'($urandom_range(0, 7)), $urandom, $urandom);
      collect("rand", i % 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 32, giving the operand and result width in bits (legal range 8..64).
REQ-002 The block SHALL have the parameter CNT_W, default $clog2(WIDTH+1), giving the multiply iteration counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port operand1, input, WIDTH bits: the first operand.
REQ-008 The block SHALL have port operand2, input, WIDTH bits: the second operand.
REQ-009 The block SHALL have port alu_control, input, 3 bits: the opcode.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port result, output, WIDTH bits: the operation result.
REQ-013 The block SHALL have port is_zero, output, 1 bit: set when result equals 0.
REQ-014 The block SHALL have port illegal_op, output, 1 bit: set when the opcode is reserved or disabled.

Function
REQ-015 The opcodes SHALL be: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 011 SLTU, 100 MUL (low WIDTH bits); 101 is reserved.
REQ-016 A request SHALL be accepted on a cycle where in_valid and in_ready are both 1; operands and opcode are captured on that edge.
REQ-017 The FSM SHALL have the states IDLE, BUSY and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-018 On acceptance of a non-MUL opcode in IDLE, the FSM SHALL move IDLE->DONE with the result registered, so out_valid rises 1 cycle after acceptance.
REQ-019 On acceptance of MUL, the FSM SHALL move IDLE->BUSY and perform an iterative shift-add, one multiplier bit per cycle, for WIDTH cycles, then BUSY->DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-020 The FSM SHALL move DONE->IDLE when out_ready=1; while out_ready=0, result, is_zero and illegal_op SHALL hold stable.
REQ-021 No new request SHALL be accepted in the cycle DONE->IDLE occurs (no bypass), so the maximum throughput is one operation per 2 cycles.
REQ-022 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-023 SLT and SLTU SHALL return 1 or 0, zero-extended to WIDTH.
REQ-024 A reserved opcode SHALL complete as a 1-cycle op with result=0, is_zero=1 and illegal_op=1.
REQ-025 is_zero SHALL be registered alongside result and SHALL be valid whenever out_valid=1.
REQ-026 Changes on the operand inputs while the FSM is in BUSY or DONE SHALL NOT affect the result.

Reset
REQ-027 On rst_n=0 the block SHALL asynchronously enter IDLE with out_valid=0, result=0, is_zero=0, illegal_op=0 and the counter cleared; in_ready=1 after release.
REQ-028 A reset asserted during BUSY or DONE SHALL abort the operation; no stale out_valid SHALL appear after release.

Configuration
REQ-029 The macro SEQ_ALU_MUL_EN SHALL control the multiplier: when defined, MUL is supported as specified.
REQ-030 When SEQ_ALU_MUL_EN is undefined, the multiplier and BUSY logic SHALL be absent and MUL SHALL behave as a reserved opcode (REQ-024).

Structure
REQ-031 The package alu_pkg SHALL hold the opcode enum (alu_op_e), the FSM state enum and the width-independent constants.
REQ-032 The multiplier SHALL be the sub-module seq_alu_mul (start/done handshake, WIDTH parameter), instantiated only under SEQ_ALU_MUL_EN.

Verification
REQ-033 The bench SHALL check: ADD 0xFFFFFFFF+0x00000001 -> result 0x00000000, is_zero=1, out_valid 1 cycle after acceptance.
REQ-034 The bench SHALL check: SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLTU with the same operands -> 0.
REQ-035 The bench SHALL check: MUL 0x00010001*0x00010001 -> 0x00020001, out_valid exactly 33 cycles after acceptance, with in_ready=0 throughout.
REQ-036 The bench SHALL check: out_ready held 0 for 5 cycles in DONE -> result stable, in_ready=0; pulsing out_ready -> IDLE on the next cycle.
REQ-037 The bench SHALL check: rst_n pulsed low at cycle 10 of a MUL -> out_valid=0 and in_ready=1 after release, and the next ADD 2+3 -> 5.
REQ-038 The bench SHALL check: opcode 101, and MUL built without SEQ_ALU_MUL_EN -> illegal_op=1, result=0, 1-cycle latency.
